// File: rtl/music_box_pkg.sv
// +----------------------------------------------------------------------+
// | music_box_pkg                                                        |
// | Shared types and constants for the music box DAC serializer.         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package music_box_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    SHIFT   = 3'd2,
    CS_HOLD = 3'd3,
    LATCH   = 3'd4
  } serState_t;

  localparam int         FRAME_BITS         = 16;
  localparam logic [3:0] DAC_CONFIG_DEFAULT = 4'b0011;

  // Two 8-bit sources summed in 9 bits; a carry clamps to full scale.
  function automatic logic [7:0] mixSaturate(input logic [7:0] song, input logic [7:0] rec);
    logic [8:0] sum;
    sum = {1'b0, song} + {1'b0, rec};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/music_box_sclk_divider.sv
// +----------------------------------------------------------------------+
// | music_box_sclk_divider                                               |
// | Phase counter producing a one-cycle enable every SCLK_DIV cycles.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module music_box_sclk_divider #(
  parameter int SCLK_DIV = 4
) (
  input  logic clock_50Mhz,
  input  logic reset_n,
  input  logic restart,
  output logic halfTick
);

  localparam logic [7:0] c_LAST_PHASE = 8'(SCLK_DIV - 1);

  logic [7:0] r_phaseCount;

  always_ff @(posedge clock_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_phaseCount <= '0;
    end else if (restart || (r_phaseCount == c_LAST_PHASE)) begin
      r_phaseCount <= '0;
    end else begin
      r_phaseCount <= r_phaseCount + 8'd1;
    end
  end

  assign halfTick = (r_phaseCount == c_LAST_PHASE);

endmodule

`default_nettype wire

// File: rtl/music_box_dac_serializer.sv
// +----------------------------------------------------------------------+
// | music_box_dac_serializer                                             |
// | Mixes song and recording audio and shifts one 16-bit SPI frame per   |
// | sample tick into the DAC, followed by an LDAC latch pulse.           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module music_box_dac_serializer
  import music_box_pkg::*;
#(
  parameter int         SCLK_DIV   = 4,
  parameter logic [3:0] DAC_CONFIG = DAC_CONFIG_DEFAULT
) (
  input  logic        clock_50Mhz,
  input  logic        reset_n,
  input  logic        sample_tick,
  input  logic [7:0]  song_audio,
  input  logic [15:0] recording_audio,
  input  logic        overrun_clear,
  output logic        dac_cs_n,
  output logic        dac_sclk,
  output logic        dac_mosi,
  output logic        dac_ldac_n,
  output logic        busy,
  output logic        overrun,
  output logic [7:0]  last_sample
);

  localparam logic [3:0] c_LAST_BIT  = 4'(FRAME_BITS - 1);
  localparam logic [3:0] c_NEXT_BASE = 4'(FRAME_BITS - 2);

  serState_t   r_state;
  logic [15:0] r_frame;
  logic [3:0]  r_bitCount;
  logic [7:0]  w_mix;
  logic        w_frameStart;
  logic        w_halfTick;
  logic        w_unusedRecHigh;

  assign w_mix           = mixSaturate(song_audio, recording_audio[7:0]);
  assign w_unusedRecHigh = ^recording_audio[15:8];
  assign w_frameStart    = sample_tick && (r_state == IDLE);
  assign busy            = (r_state != IDLE);

  music_box_sclk_divider #(
    .SCLK_DIV (SCLK_DIV)
  ) u_sclkDivider (
    .clock_50Mhz (clock_50Mhz),
    .reset_n     (reset_n),
    .restart     (w_frameStart),
    .halfTick    (w_halfTick)
  );

  always_ff @(posedge clock_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_frame     <= '0;
      r_bitCount  <= '0;
      dac_cs_n    <= 1'b1;
      dac_sclk    <= 1'b0;
      dac_mosi    <= 1'b0;
      dac_ldac_n  <= 1'b1;
      last_sample <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (sample_tick) begin
            r_frame     <= {DAC_CONFIG, w_mix, 4'b0000};
            last_sample <= w_mix;
            r_bitCount  <= '0;
            dac_cs_n    <= 1'b0;
            dac_sclk    <= 1'b0;
            dac_mosi    <= DAC_CONFIG[3];
            r_state     <= SETUP;
          end
        end
        SETUP: begin
          if (w_halfTick) r_state <= SHIFT;
        end
        SHIFT: begin
          if (w_halfTick) begin
            if (!dac_sclk) begin
              dac_sclk <= 1'b1;
            end else begin
              // Data moves only on the falling edge so it is settled at every rise.
              dac_sclk <= 1'b0;
              if (r_bitCount == c_LAST_BIT) begin
                dac_cs_n <= 1'b1;
                dac_mosi <= 1'b0;
                r_state  <= CS_HOLD;
              end else begin
                dac_mosi   <= r_frame[c_NEXT_BASE - r_bitCount];
                r_bitCount <= r_bitCount + 4'd1;
              end
            end
          end
        end
        CS_HOLD: begin
          if (w_halfTick) begin
            dac_ldac_n <= 1'b0;
            r_state    <= LATCH;
          end
        end
        LATCH: begin
          if (w_halfTick) begin
            dac_ldac_n <= 1'b1;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // A dropped tick sets the flag even when a clear arrives in the same cycle.
  always_ff @(posedge clock_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      overrun <= 1'b0;
    end else if (sample_tick && busy) begin
      overrun <= 1'b1;
    end else if (overrun_clear) begin
      overrun <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_music_box_dac_serializer.sv
// +----------------------------------------------------------------------+
// | tb_music_box_dac_serializer                                          |
// | Directed bench for a default build and an SCLK_DIV=2 build.          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_music_box_dac_serializer;

  logic        clk;
  logic        reset_n;
  logic [1:0]  tick;
  logic [7:0]  song;
  logic [15:0] rec;
  logic        clearA;
  logic        clearB;
  logic [1:0]  csV, sclkV, mosiV, ldacV, busyV, ovrV;
  logic [7:0]  lastA, lastB;

  int checks = 0;
  int errors = 0;

  music_box_dac_serializer u_dutA (
    .clock_50Mhz     (clk),
    .reset_n         (reset_n),
    .sample_tick     (tick[0]),
    .song_audio      (song),
    .recording_audio (rec),
    .overrun_clear   (clearA),
    .dac_cs_n        (csV[0]),
    .dac_sclk        (sclkV[0]),
    .dac_mosi        (mosiV[0]),
    .dac_ldac_n      (ldacV[0]),
    .busy            (busyV[0]),
    .overrun         (ovrV[0]),
    .last_sample     (lastA)
  );

  music_box_dac_serializer #(.SCLK_DIV(2)) u_dutB (
    .clock_50Mhz     (clk),
    .reset_n         (reset_n),
    .sample_tick     (tick[1]),
    .song_audio      (song),
    .recording_audio (rec),
    .overrun_clear   (clearB),
    .dac_cs_n        (csV[1]),
    .dac_sclk        (sclkV[1]),
    .dac_mosi        (mosiV[1]),
    .dac_ldac_n      (ldacV[1]),
    .busy            (busyV[1]),
    .overrun         (ovrV[1]),
    .last_sample     (lastB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SPI mode-0 monitor, sampled 2 time units after each rising clock edge.
  int          csRun[2]      = '{0, 0};
  int          csLast[2]     = '{0, 0};
  int          ldacRun[2]    = '{0, 0};
  int          ldacLast[2]   = '{0, 0};
  int          ldacPulses[2] = '{0, 0};
  int          busyRun[2]    = '{0, 0};
  int          busyLast[2]   = '{0, 0};
  int          bits[2]       = '{0, 0};
  int          bitsLast[2]   = '{0, 0};
  int          viol[2]       = '{0, 0};
  int          frames[2]     = '{0, 0};
  logic [15:0] shiftR[2]     = '{16'h0, 16'h0};
  logic [15:0] frameLast[2]  = '{16'h0, 16'h0};
  logic [1:0]  prevCs = 2'b11, prevLdac = 2'b11, prevBusy = 2'b00, prevSclk = 2'b00, prevMosi = 2'b00;

  always @(posedge clk) begin
    #2;
    for (int k = 0; k < 2; k++) begin
      if (sclkV[k] && !prevSclk[k]) begin
        shiftR[k] = {shiftR[k][14:0], mosiV[k]};
        bits[k]++;
        if (mosiV[k] !== prevMosi[k]) viol[k]++;
      end
      if (!csV[k]) csRun[k]++;
      else if (!prevCs[k]) begin
        csLast[k] = csRun[k]; csRun[k] = 0;
        frameLast[k] = shiftR[k]; bitsLast[k] = bits[k]; bits[k] = 0;
        frames[k]++;
      end
      if (!ldacV[k]) ldacRun[k]++;
      else if (!prevLdac[k]) begin
        ldacLast[k] = ldacRun[k]; ldacRun[k] = 0; ldacPulses[k]++;
      end
      if (busyV[k]) busyRun[k]++;
      else if (prevBusy[k]) begin
        busyLast[k] = busyRun[k]; busyRun[k] = 0;
      end
      prevCs[k] = csV[k]; prevLdac[k] = ldacV[k]; prevBusy[k] = busyV[k];
      prevSclk[k] = sclkV[k]; prevMosi[k] = mosiV[k];
    end
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic startFrame(input int k, input logic [7:0] s, input logic [15:0] r);
    song = s; rec = r; tick[k] = 1'b1;
    @(negedge clk);
    tick[k] = 1'b0;
    checkVal("frameStart", 32'(busyV[k]), 32'd1);
  endtask

  task automatic waitIdle(input int k);
    int n = 0;
    while (busyV[k] && n < 400) begin
      @(negedge clk);
      n++;
    end
    checkVal("frameDone", 32'(busyV[k]), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic checkFrame(input int k, input logic [15:0] f, input logic [7:0] l, input int d);
    checkVal("frame", 32'(frameLast[k]), 32'(f));
    checkVal("lastSample", 32'(k == 0 ? lastA : lastB), 32'(l));
    checkVal("bits", bitsLast[k], 16);
    checkVal("csLow", csLast[k], 33 * d);
    checkVal("ldacWidth", ldacLast[k], d);
    checkVal("frameLen", busyLast[k], 35 * d);
    checkVal("mosiStable", viol[k], 0);
  endtask

  task automatic checkResetState(input string tag);
    checkVal({tag, "_cs"},   32'(csV[0]),   32'd1);
    checkVal({tag, "_sclk"}, 32'(sclkV[0]), 32'd0);
    checkVal({tag, "_mosi"}, 32'(mosiV[0]), 32'd0);
    checkVal({tag, "_ldac"}, 32'(ldacV[0]), 32'd1);
    checkVal({tag, "_busy"}, 32'(busyV[0]), 32'd0);
    checkVal({tag, "_ovr"},  32'(ovrV[0]),  32'd0);
    checkVal({tag, "_last"}, 32'(lastA),    32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, f0;
    reset_n = 1'b0; tick = 2'b00; song = 8'h00; rec = 16'h0000; clearA = 1'b0; clearB = 1'b0;
    repeat (3) @(negedge clk);
    checkResetState("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic frame
    startFrame(0, 8'h40, 16'h0010); waitIdle(0);
    checkFrame(0, 16'h3500, 8'h50, 4);
    checkVal("ldacPulses", ldacPulses[0], 1);

    // Saturation and ignored upper recording bits
    startFrame(0, 8'hC0, 16'h0080); waitIdle(0);
    checkFrame(0, 16'h3FF0, 8'hFF, 4);
    startFrame(0, 8'h00, 16'hAB00); waitIdle(0);
    checkFrame(0, 16'h3000, 8'h00, 4);
    startFrame(0, 8'h12, 16'h1234); waitIdle(0);
    checkFrame(0, 16'h3460, 8'h46, 4);
    startFrame(0, 8'h80, 16'h007F); waitIdle(0);
    checkFrame(0, 16'h3FF0, 8'hFF, 4);

    // Overrun: late tick with changed inputs is dropped
    startFrame(0, 8'h40, 16'h0010);
    repeat (49) @(negedge clk);
    song = 8'h11; tick[0] = 1'b1;
    @(negedge clk);
    tick[0] = 1'b0;
    checkVal("ovrSet", 32'(ovrV[0]), 32'd1);
    waitIdle(0);
    checkFrame(0, 16'h3500, 8'h50, 4);
    clearA = 1'b1; @(negedge clk); clearA = 1'b0;
    checkVal("ovrClear", 32'(ovrV[0]), 32'd0);
    startFrame(0, 8'h11, 16'h0000);
    repeat (20) @(negedge clk);
    tick[0] = 1'b1; clearA = 1'b1;
    @(negedge clk);
    tick[0] = 1'b0; clearA = 1'b0;
    checkVal("ovrSetWins", 32'(ovrV[0]), 32'd1);
    waitIdle(0);
    checkFrame(0, 16'h3110, 8'h11, 4);
    clearA = 1'b1; @(negedge clk); clearA = 1'b0;
    checkVal("ovrClear2", 32'(ovrV[0]), 32'd0);

    // Back-to-back at the sample rate
    f0 = frames[0]; p0 = ldacPulses[0];
    for (int i = 0; i < 8; i++) begin
      song = 8'(8'h10 * i + 1); rec = 16'(i); tick[0] = 1'b1;
      @(negedge clk);
      tick[0] = 1'b0;
      repeat (2271) @(negedge clk);
    end
    checkVal("b2bFrames", frames[0] - f0, 8);
    checkVal("b2bLdac", ldacPulses[0] - p0, 8);
    checkVal("b2bOvr", 32'(ovrV[0]), 32'd0);
    checkVal("b2bFrame", 32'(frameLast[0]), 32'h3780);

    // Tick on the LATCH->IDLE edge is dropped; the next one is accepted
    startFrame(0, 8'h71, 16'h0007);
    repeat (139) @(negedge clk);
    tick[0] = 1'b1;
    checkVal("latchBusy", 32'(busyV[0]), 32'd1);
    checkVal("latchLdac", 32'(ldacV[0]), 32'd0);
    @(negedge clk);
    checkVal("edgeOvr", 32'(ovrV[0]), 32'd1);
    checkVal("edgeIdle", 32'(busyV[0]), 32'd0);
    @(negedge clk);
    tick[0] = 1'b0;
    checkVal("edgeRestart", 32'(busyV[0]), 32'd1);
    waitIdle(0);
    checkFrame(0, 16'h3780, 8'h78, 4);

    // Reset in the middle of bit 7
    startFrame(0, 8'hA5, 16'h0003);
    repeat (61) @(negedge clk);
    checkVal("bitsBeforeReset", bits[0], 7);
    p0 = ldacPulses[0];
    reset_n = 1'b0;
    #1;
    checkResetState("midReset");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (200) @(negedge clk);
    checkVal("noLdacAfterAbort", ldacPulses[0] - p0, 0);
    startFrame(0, 8'h3C, 16'h0042); waitIdle(0);
    checkFrame(0, 16'h37E0, 8'h7E, 4);
    checkVal("ldacAfterReset", ldacPulses[0] - p0, 1);

    // SCLK_DIV=2 build
    startFrame(1, 8'h5A, 16'h0021); waitIdle(1);
    checkFrame(1, 16'h37B0, 8'h7B, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
